// File: rtl/operation_s.sv
// Superposition controller: computes F(G0(x), ..., G(N-1)(x)).
// It latches the argument vector, starts every Gi block in parallel and waits
// until all of them report ready. It then hands the collected Gi results to F,
// starts F, and returns F's result on RES.
// All block-to-block links use the ST/RD handshake: a 0->1 edge on ST starts
// a block, and RD=1 means the block is idle and its result is valid.
//
// Ports:
//   CLK     clock; all state changes on the rising edge
//   RST     asynchronous, active-high reset
//   ST      start; a 0->1 transition starts an operation while idle
//   RD      ready: 1 = idle / result valid, 0 = busy
//   RES     F result; holds its value until the next completion
//   IN      arguments x, argument j at [j*BW +: BW]
//   X       registered copy of IN, fanned out to every Gi
//   G_ST    per-Gi start pulse (bit i)
//   G_RD    per-Gi ready (bit i)
//   G_RES   Gi results, Gi at [i*BW +: BW]
//   F_ARGS  registered Gi results, fanned out to F
//   F_ST    start pulse to F
//   F_RD    ready from F
//   F_RES   result from F
module operation_s #(
    parameter int unsigned BW = 16,
    parameter int unsigned N  = 3,
    parameter int unsigned K  = 3
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            ST,
    output logic            RD,
    output logic [BW-1:0]   RES,
    input  logic [K*BW-1:0] IN,
    output logic [K*BW-1:0] X,
    output logic [N-1:0]    G_ST,
    input  logic [N-1:0]    G_RD,
    input  logic [N*BW-1:0] G_RES,
    output logic [N*BW-1:0] F_ARGS,
    output logic            F_ST,
    input  logic            F_RD,
    input  logic [BW-1:0]   F_RES
);

    localparam int unsigned XW = K * BW;
    localparam int unsigned GW = N * BW;

    typedef enum logic [2:0] {
        IDLE,
        G_START,
        G_ARM,
        G_WAIT,
        F_START,
        F_ARM,
        F_WAIT
    } state_t;

    state_t state;
    logic   st_old;
    logic   st_rise;
    logic   g_all_rd;

    assign st_rise  = ST && !st_old;
    assign g_all_rd = &G_RD;

    // Sequencer. The *_ARM states give each peer one edge to drop its RD
    // after seeing its start pulse, so a stale RD=1 is never mistaken for
    // completion.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state  <= IDLE;
            st_old <= 1'b0;
            RD     <= 1'b1;
            RES    <= '0;
            X      <= '0;
            F_ARGS <= '0;
            G_ST   <= '0;
            F_ST   <= 1'b0;
        end else begin
            st_old <= ST;
            case (state)
                IDLE: begin
                    if (st_rise) begin
                        X     <= XW'(IN);
                        RD    <= 1'b0;
                        G_ST  <= '1;
                        state <= G_START;
                    end
                end
                G_START: begin
                    G_ST  <= '0;
                    state <= G_ARM;
                end
                G_ARM: begin
                    state <= G_WAIT;
                end
                G_WAIT: begin
                    if (g_all_rd) begin
                        F_ARGS <= GW'(G_RES);
                        F_ST   <= 1'b1;
                        state  <= F_START;
                    end
                end
                F_START: begin
                    F_ST  <= 1'b0;
                    state <= F_ARM;
                end
                F_ARM: begin
                    state <= F_WAIT;
                end
                F_WAIT: begin
                    if (F_RD) begin
                        RES   <= BW'(F_RES);
                        RD    <= 1'b1;
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_operation_s.sv
// Self-checking bench for operation_s. It contains projection peer blocks for
// Gi/F with programmable latency, a transaction-timeline reference model, a
// per-cycle compare process, directed scenarios and a randomized phase.
module tb_operation_s;

    localparam int unsigned BW = 16;
    localparam int unsigned N  = 3;
    localparam int unsigned K  = 3;

    logic            CLK;
    logic            RST;
    logic            ST;
    logic            RD;
    logic [BW-1:0]   RES;
    logic [K*BW-1:0] IN;
    logic [K*BW-1:0] X;
    logic [N-1:0]    G_ST;
    logic [N-1:0]    G_RD;
    logic [N*BW-1:0] G_RES;
    logic [N*BW-1:0] F_ARGS;
    logic            F_ST;
    logic            F_RD;
    logic [BW-1:0]   F_RES;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    operation_s #(.BW(BW), .N(N), .K(K)) dut (
        .CLK(CLK), .RST(RST), .ST(ST), .RD(RD), .RES(RES), .IN(IN), .X(X),
        .G_ST(G_ST), .G_RD(G_RD), .G_RES(G_RES), .F_ARGS(F_ARGS),
        .F_ST(F_ST), .F_RD(F_RD), .F_RES(F_RES)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    always @(posedge CLK) cyc <= cyc + 1;

    // Gi projection: G0=x2, G1=x0, G2=x1. F returns its argument 1.
    function automatic int proj_f(input int i);
        case (i)
            0: return 2;
            1: return 0;
            default: return 1;
        endcase
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- peer blocks ----------------
    int            glat [N];
    int            flat;
    logic          g_rd    [N];
    int            g_cnt   [N];
    logic          g_stold [N];
    logic [BW-1:0] g_val   [N];
    logic [BW-1:0] g_res   [N];
    logic          f_rd, f_stold;
    int            f_cnt;
    logic [BW-1:0] f_val, f_res;

    always_comb begin
        G_RD  = '0;
        G_RES = '0;
        for (int i = 0; i < N; i++) begin
            G_RD[i]           = g_rd[i];
            G_RES[i*BW +: BW] = g_res[i];
        end
        F_RD  = f_rd;
        F_RES = f_res;
    end

    always @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < N; i++) begin
                g_rd[i]    <= 1'b1;
                g_cnt[i]   <= 0;
                g_stold[i] <= 1'b0;
                g_val[i]   <= '0;
                g_res[i]   <= '0;
            end
        end else begin
            for (int i = 0; i < N; i++) begin
                g_stold[i] <= G_ST[i];
                if (G_ST[i] && !g_stold[i]) begin
                    g_rd[i]  <= 1'b0;
                    g_cnt[i] <= glat[i];
                    g_val[i] <= X[proj_f(i)*BW +: BW];
                    g_res[i] <= 16'hDEAD;
                end else if (!g_rd[i]) begin
                    if (g_cnt[i] <= 1) begin
                        g_rd[i]  <= 1'b1;
                        g_res[i] <= g_val[i];
                    end else begin
                        g_cnt[i] <= g_cnt[i] - 1;
                    end
                end
            end
        end
    end

    always @(posedge CLK or posedge RST) begin
        if (RST) begin
            f_rd    <= 1'b1;
            f_cnt   <= 0;
            f_stold <= 1'b0;
            f_val   <= '0;
            f_res   <= '0;
        end else begin
            f_stold <= F_ST;
            if (F_ST && !f_stold) begin
                f_rd  <= 1'b0;
                f_cnt <= flat;
                f_val <= F_ARGS[BW +: BW];
                f_res <= 16'hBAD0;
            end else if (!f_rd) begin
                if (f_cnt <= 1) begin
                    f_rd  <= 1'b1;
                    f_res <= f_val;
                end else begin
                    f_cnt <= f_cnt - 1;
                end
            end
        end
    end

    // ---------------- reference model ----------------
    // Timeline view: an accepted start at edge 0 pulses G_ST there, F_ST and
    // F_ARGS appear at edge 3 + extra Gi latency, completion follows 3 + extra
    // F latency edges later.
    logic            m_busy, m_stold, m_gst, m_fst;
    logic [K*BW-1:0] m_x;
    logic [N*BW-1:0] m_fargs;
    logic [BW-1:0]   m_res;
    int              m_age, m_fst_age, m_done_age;

    function automatic int gmax_f();
        int m = 1;
        for (int i = 0; i < N; i++) if (glat[i] > m) m = glat[i];
        return m;
    endfunction

    function automatic logic [N*BW-1:0] fargs_f(input logic [K*BW-1:0] x);
        logic [N*BW-1:0] r = '0;
        for (int i = 0; i < N; i++) r[i*BW +: BW] = x[proj_f(i)*BW +: BW];
        return r;
    endfunction

    always @(posedge CLK or posedge RST) begin
        if (RST) begin
            m_busy <= 1'b0; m_stold <= 1'b0; m_gst <= 1'b0; m_fst <= 1'b0;
            m_x <= '0; m_fargs <= '0; m_res <= '0;
            m_age <= 0; m_fst_age <= 0; m_done_age <= 0;
        end else begin
            m_stold <= ST;
            m_gst   <= 1'b0;
            m_fst   <= 1'b0;
            if (!m_busy && ST && !m_stold) begin
                m_busy     <= 1'b1;
                m_x        <= IN;
                m_gst      <= 1'b1;
                m_age      <= 0;
                m_fst_age  <= 3 + gmax_f() - 1;
                m_done_age <= 3 + gmax_f() - 1 + 3 + flat - 1;
            end else if (m_busy) begin
                m_age <= m_age + 1;
                if (m_age + 1 == m_fst_age) begin
                    m_fst   <= 1'b1;
                    m_fargs <= fargs_f(m_x);
                end
                if (m_age + 1 == m_done_age) begin
                    m_busy <= 1'b0;
                    m_res  <= m_x[proj_f(1)*BW +: BW];
                end
            end
        end
    end

    // Per-cycle compare, sampled away from the rising edge.
    always @(negedge CLK) begin
        if (!RST) begin
            chk("rd", 64'(RD), 64'(!m_busy));
            chk("res", 64'(RES), 64'(m_res));
            chk("x", 64'(X), 64'(m_x));
            chk("f_args", 64'(F_ARGS), 64'(m_fargs));
            chk("g_st", 64'(G_ST), 64'({N{m_gst}}));
            chk("f_st", 64'(F_ST), 64'(m_fst));
        end
    end

    // ---------------- directed helpers ----------------
    task automatic run_wait(input int e0, input int budget, input bit chg_in, input bit toggle,
                            output int done_c, output int gst_n, output int fst_c,
                            output logic [N-1:0] gst_v);
        done_c = -1; gst_n = 0; fst_c = -1; gst_v = '0;
        for (int n = 0; n < budget; n++) begin
            @(negedge CLK);
            if (G_ST != '0) begin gst_n++; gst_v = G_ST; end
            if (F_ST && fst_c < 0) fst_c = cyc;
            if (RD) begin done_c = cyc; break; end
            if (chg_in && cyc == e0 + 1) IN[BW-1:0] = 16'h1234;
            if (toggle) ST = ~ST;
        end
        chk("done_timeout", 64'(done_c >= 0), 64'd1);
    endtask

    localparam logic [K*BW-1:0] IN_NOM = {16'h00FF, 16'h0009, 16'h0005};

    int e0, done_c, gst_n, fst_c;
    logic [N-1:0] gst_v;

    initial begin
        RST = 1'b1; ST = 1'b0; IN = '0; flat = 1;
        for (int i = 0; i < N; i++) glat[i] = 1;
        repeat (2) @(negedge CLK);
        chk("rst_rd", 64'(RD), 64'd1);
        chk("rst_res", 64'(RES), 64'd0);
        chk("rst_gst", 64'(G_ST), 64'd0);
        RST = 1'b0;
        @(negedge CLK);

        // Nominal, with IN disturbed at e1.
        IN = IN_NOM; ST = 1'b1; e0 = cyc + 1;
        run_wait(e0, 40, 1'b1, 1'b0, done_c, gst_n, fst_c, gst_v);
        chk("nom_latency", 64'(done_c - e0), 64'd6);
        chk("nom_res", 64'(RES), 64'h5);
        chk("nom_gst_pulses", 64'(gst_n), 64'd1);
        chk("nom_gst_val", 64'(gst_v), 64'h7);
        chk("nom_x0", 64'(X[BW-1:0]), 64'h5);
        chk("nom_fargs", 64'(F_ARGS), 64'h0009_0005_00FF);
        ST = 1'b0; IN = IN_NOM;
        @(negedge CLK);

        // Skewed G1 plus ST retriggering throughout the busy period.
        glat[1] = 7; ST = 1'b1; e0 = cyc + 1;
        run_wait(e0, 40, 1'b0, 1'b1, done_c, gst_n, fst_c, gst_v);
        chk("skew_latency", 64'(done_c - e0), 64'd12);
        chk("skew_fst_time", 64'(fst_c - e0), 64'd9);
        chk("skew_fargs", 64'(F_ARGS), 64'h0009_0005_00FF);
        chk("skew_gst_pulses", 64'(gst_n), 64'd1);
        chk("skew_res", 64'(RES), 64'h5);
        chk("skew_x", 64'(X), 64'(IN_NOM));
        @(negedge CLK); ST = 1'b0;
        @(negedge CLK);

        // Asynchronous reset inside G_WAIT.
        ST = 1'b1; e0 = cyc + 1;
        repeat (6) @(negedge CLK);
        #2 RST = 1'b1;
        #1;
        chk("arst_rd", 64'(RD), 64'd1);
        chk("arst_gst", 64'(G_ST), 64'd0);
        chk("arst_fst", 64'(F_ST), 64'd0);
        chk("arst_res", 64'(RES), 64'd0);
        chk("arst_x", 64'(X), 64'd0);
        chk("arst_fargs", 64'(F_ARGS), 64'd0);
        @(negedge CLK); ST = 1'b0; glat[1] = 1;
        @(negedge CLK); RST = 1'b0;
        @(negedge CLK);
        ST = 1'b1; e0 = cyc + 1;
        run_wait(e0, 40, 1'b0, 1'b0, done_c, gst_n, fst_c, gst_v);
        chk("post_rst_latency", 64'(done_c - e0), 64'd6);
        chk("post_rst_res", 64'(RES), 64'h5);

        // ST held high after completion must not restart.
        repeat (3) begin
            @(negedge CLK);
            chk("hold_rd", 64'(RD), 64'd1);
            chk("hold_gst", 64'(G_ST), 64'd0);
        end
        ST = 1'b0; IN = {16'h00FF, 16'h0009, 16'hBEEF};
        @(negedge CLK);
        ST = 1'b1; e0 = cyc + 1;
        run_wait(e0, 40, 1'b0, 1'b0, done_c, gst_n, fst_c, gst_v);
        chk("b2b_latency", 64'(done_c - e0), 64'd6);
        chk("b2b_res", 64'(RES), 64'hBEEF);

        // Randomized phase: random ST, IN, peer latencies and rare resets.
        for (int n = 0; n < 3000; n++) begin
            @(negedge CLK);
            if (RST) RST = 1'b0;
            if (!m_busy && $urandom_range(0, 1) == 0) begin
                for (int i = 0; i < N; i++) glat[i] = int'($urandom_range(1, 5));
                flat = int'($urandom_range(1, 4));
            end
            ST = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 1) == 0) IN = {16'($urandom), 16'($urandom), 16'($urandom)};
            if ($urandom_range(0, 299) == 0) #2 RST = 1'b1;
        end
        @(negedge CLK);
        RST = 1'b0;
        repeat (2) @(negedge CLK);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/operation_s.md
Name: operation_s

Overview:
- Superposition controller: computes F(G0(x), …, G(N-1)(x)) by sequencing external operation blocks.
- Uses the codebase ST/RD handshake. The inner Gi and outer F blocks (operation_i and peers) are instantiated beside it by the generator.
- Latches the argument vector, starts all Gi in parallel, and waits for every Gi RD.
- Then feeds the collected Gi results to F, starts F, and returns F's result on RES with its own ST/RD handshake.

Parameters:
BW, 16, bit width of every argument and result
N, 3, number of inner functions Gi (1..8)
K, 3, number of arguments x (1..8)

Ports:
CLK  in  1  clock, all state on rising edge
RST  in  1  reset, asynchronous, active-high
ST  in  1  start; a rising edge (ST=1, previous sampled ST=0) starts an operation
RD  out  1  ready; 1 = idle/result valid, 0 = busy
RES  out  BW  result, valid while RD=1 after completion
IN  in  K*BW  arguments x, argument j at bits [j*BW +: BW]
X  out  K*BW  registered copy of IN, wired to all Gi argument inputs
G_ST  out  N  start to Gi (bit i)
G_RD  in  N  ready from Gi (bit i)
G_RES  in  N*BW  results from Gi, Gi at [i*BW +: BW]
F_ARGS  out  N*BW  registered Gi results, wired to F argument inputs
F_ST  out  1  start to F
F_RD  in  1  ready from F
F_RES  in  BW  result from F

Behaviour:
- Reset is asynchronous. While RST=1, all of the following hold:
  - State is IDLE.
  - RD=1.
  - RES=0, X=0, F_ARGS=0.
  - G_ST=0, F_ST=0.
  - STold=0.
- Reset mid-operation aborts immediately. There is no pending restart after release.
- STold is updated with ST every cycle regardless of state.
- States: IDLE, G_START, G_ARM, G_WAIT, F_START, F_ARM, F_WAIT.
- IDLE: on (ST=1 && STold=0), at the same edge:
  - X <= IN;
  - RD <= 0;
  - G_ST <= all ones;
  - go to G_START.
- G_START:
  - G_ST <= 0 (pulse is exactly 1 cycle);
  - go to G_ARM.
- G_ARM:
  - go to G_WAIT unconditionally.
  - G_RD is ignored in G_START and G_ARM, because Gi drop RD one edge after seeing their ST.
- G_WAIT: when G_RD == all ones:
  - F_ARGS <= G_RES;
  - F_ST <= 1;
  - go to F_START.
  - Otherwise stay. There is no timeout.
- F_START:
  - F_ST <= 0;
  - go to F_ARM.
- F_ARM:
  - go to F_WAIT. F_RD is ignored in F_START and F_ARM.
- F_WAIT: when F_RD=1:
  - RES <= F_RES;
  - RD <= 1;
  - go to IDLE.
- ST edges while RD=0 are ignored, not queued. ST held high after completion does not restart; a new 0->1 transition is required.
- RES holds its last value until the next completion. RES is not cleared at start.
- Latency with 1-cycle Gi and F: the ST edge is sampled at edge e0; RD=1 and RES valid after edge e6.
- Latency in general: 6 + (Gmax extra cycles) + (F extra cycles).
- X and F_ARGS are stable from their capture until the next start.
- Gi finishing at different times is allowed; completion is the first cycle in G_WAIT with all bits set.
- No arithmetic: pure data movement, widths exactly as the ports.

Test Plan:
- Reset: RST=1 asynchronously mid-G_WAIT -> RD=1, G_ST=0, F_ST=0, RES=0 immediately, before the next clock; the next ST edge performs a full operation.
- Nominal: BW=16, N=3, K=3, IN={x0=5, x1=9, x2=0x00FF}. Gi are projection models (G0=x2, G1=x0, G2=x1, latency 1); F is the projection of argument 1 (latency 1). Expected: RES=5, RD rises exactly after e6, G_ST is a single 3'b111 pulse.
- Skewed Gi: same stimulus with G1 completing 7 cycles after its start. Expected: F_ST not asserted until G1 RD returns; F_ARGS={x1, x0, x2}; RD rises after e12.
- Retrigger: ST toggled 0-1-0-1 during G_WAIT and F_WAIT -> no second G_ST pulse and no change to X.
- IN changes at e1 from 5 to 0x1234 while busy -> X and RES still reflect 5.
- Back-to-back: ST held high through completion -> no restart. ST dropped and re-raised the cycle after RD=1 with IN x0=0xBEEF -> second operation yields RES=0xBEEF in 6 cycles.
